ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares one single-port data/instruction RAM between the MEM stage (data port D) and instruction fetch (port I).
- Grants the RAM to one requester at a time and holds that request in registers while the RAM works.
- Returns busy/done/rdata to the requester in the form the MEM stage already consumes. A request is issued when busy=0; the result is taken on the one-cycle done pulse.
- Sits between the pipeline and the RAM model/bus.

Parameters:
MAX_D_STREAK, 4, consecutive D grants allowed while I is pending before I is forced a grant
TIMEOUT, 255, cycles in a bus state without mem_ack before the transaction is aborted with an error
CNT_W, 8, width of the timeout counter; must satisfy TIMEOUT < 2**CNT_W

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset
d_ce  in  1  data request
d_we  in  1  data write enable
d_addr  in  32  data address (passed through, no alignment check)
d_wdata  in  32  store data
d_sel  in  4  byte select
d_rdata  out  32  load data, valid on d_done
d_busy  out  1  D must wait
d_done  out  1  D transaction complete (1-cycle pulse)
i_ce  in  1  fetch request (read only, sel 4'b1111)
i_addr  in  32  fetch address
i_rdata  out  32  fetched word, valid on i_done
i_busy  out  1  I must wait
i_done  out  1  I transaction complete (1-cycle pulse)
mem_req  out  1  RAM request, held until ack
mem_we  out  1  RAM write enable
mem_addr  out  32  RAM address
mem_wdata  out  32  RAM write data
mem_sel  out  4  RAM byte select
mem_ack  in  1  RAM completion, 1 cycle
mem_rdata  in  32  RAM read data, valid with mem_ack
bus_err  out  1  timeout indication, pulses with done

Behaviour:
- Reset is rst: synchronous, active-high. On reset:
  - state goes to IDLE; the streak and timeout counters clear.
  - every output is 0, including rdata regs, mem_* and bus_err.
  - an in-flight transaction is abandoned; mem_req is low after that edge and no done pulse is produced.
- States: IDLE, BUS_D, BUS_I, DONE_D, DONE_I. All outputs are registered.
- IDLE arbitration:
  - If d_ce=1 and not (i_ce=1 and streak==MAX_D_STREAK): latch d_we/d_addr/d_wdata/d_sel, go to BUS_D, streak+1 (saturating).
  - Else if i_ce=1: latch i_addr with we=0, wdata=0, sel=4'b1111; go to BUS_I; streak=0.
  - Else stay in IDLE.
  - If d_ce and i_ce are both high, D wins unless the streak limit is reached.
  - An I grant always clears streak. A D grant with i_ce=0 leaves streak at 0.
- BUS_x:
  - mem_req=1 and mem_* are driven from the latched registers and held stable until ack.
  - On mem_ack=1: x_rdata <= mem_rdata for reads and 0 for writes; go to DONE_x.
  - mem_ack outside BUS states is ignored.
  - The timeout counter increments each BUS cycle. When it reaches TIMEOUT without ack: x_rdata <= 0, bus_err=1 in DONE_x, go to DONE_x.
- DONE_x:
  - x_done=1, x_busy=0, mem_req=0 for exactly one cycle, then go to IDLE.
  - No grant is made in DONE (x_ce is still high from the completing instruction). This prevents a double issue.
  - x_rdata holds its value until the next completion on that port.
- busy rules:
  - x_busy=1 in every state except IDLE and DONE_x.
  - In IDLE both busy=0.
  - The non-owner's busy stays 1 through the owner's DONE cycle.
- Latency: ce sampled at edge 0; mem_req high after edge 0; ack earliest in that same cycle; done high after edge 1 (minimum 2 cycles ce→done); IDLE again after edge 2.
- Ordering: one outstanding transaction only. Requests are never queued; a requester keeps ce high until it sees done.
- bus_err is 0 except in a DONE cycle entered by timeout.
- If ce drops during BUS_x, the transaction still completes and done still pulses.

Test Plan:
- D read, RAM acks 1 cycle after req with mem_rdata=32'hDEADBEEF -> mem_addr=d_addr, mem_sel=d_sel, mem_we=0; d_done pulses 1 cycle with d_rdata=32'hDEADBEEF; i_busy=1 throughout; no second mem_req while d_ce is still high in DONE.
- d_ce and i_ce both high continuously, ack every cycle -> grant order D,D,D,D,I,D,D,D,D,I; streak clears on each I grant.
- D write sw to 32'h100, wdata 32'h12345678, sel 4'b1111 -> mem_we=1 and mem_wdata held until ack; d_rdata=0 on d_done; bus_err=0.
- No ack for TIMEOUT=255 cycles on an I fetch -> i_done and bus_err pulse together, i_rdata=0; next cycle IDLE; a subsequent D request is granted.
- rst asserted mid BUS_D -> next cycle all outputs 0, no d_done; a fresh d_ce after reset completes normally.
- Ack arriving in IDLE or DONE -> ignored; no done pulse and no rdata change.

Source files
------------

// File: rtl/ram_arbiter.sv
// Arbitrates one single-port RAM between the MEM-stage data port (D) and
// instruction fetch (I). One transaction at a time, all outputs registered.
module ram_arbiter #(
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 255,
  parameter int CNT_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        d_ce,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_sel,
  output logic [31:0] d_rdata,
  output logic        d_busy,
  output logic        d_done,
  input  logic        i_ce,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_busy,
  output logic        i_done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_sel,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        bus_err
);

  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
  localparam logic [CNT_W-1:0]    TMO_LAST   = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUS_D  = 3'd1,
    BUS_I  = 3'd2,
    DONE_D = 3'd3,
    DONE_I = 3'd4
  } state_t;

  state_t              state;
  logic [STREAK_W-1:0] streak;
  logic [CNT_W-1:0]    tmo_cnt;

  // Handshake: a port issues by holding x_ce while x_busy=0 and keeps x_ce high
  // until it sees the single-cycle x_done; x_rdata is valid on that pulse.
  // RAM side: mem_req and mem_* stay stable until a one-cycle mem_ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      streak    <= '0;
      tmo_cnt   <= '0;
      d_rdata   <= '0;
      d_busy    <= 1'b0;
      d_done    <= 1'b0;
      i_rdata   <= '0;
      i_busy    <= 1'b0;
      i_done    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_sel   <= '0;
      bus_err   <= 1'b0;
    end else begin
      d_done  <= 1'b0;
      i_done  <= 1'b0;
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (d_ce && !(i_ce && streak == STREAK_MAX)) begin
            state     <= BUS_D;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_sel   <= d_sel;
            d_busy    <= 1'b1;
            i_busy    <= 1'b1;
            // Streak only counts D grants that made a pending fetch wait.
            if (!i_ce)
              streak <= '0;
            else if (streak != STREAK_MAX)
              streak <= streak + 1'b1;
          end else if (i_ce) begin
            state     <= BUS_I;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
            mem_sel   <= 4'b1111;
            d_busy    <= 1'b1;
            i_busy    <= 1'b1;
            streak    <= '0;
          end
        end
        BUS_D, BUS_I: begin
          if (mem_ack || tmo_cnt == TMO_LAST) begin
            mem_req <= 1'b0;
            bus_err <= !mem_ack;
            if (state == BUS_D) begin
              state   <= DONE_D;
              d_done  <= 1'b1;
              d_busy  <= 1'b0;
              d_rdata <= (mem_ack && !mem_we) ? mem_rdata : '0;
            end else begin
              state   <= DONE_I;
              i_done  <= 1'b1;
              i_busy  <= 1'b0;
              i_rdata <= mem_ack ? mem_rdata : '0;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        DONE_D, DONE_I: begin
          // No grant here: the finishing requester's ce is still high.
          state  <= IDLE;
          d_busy <= 1'b0;
          i_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: linear steps, immediate-assertion checks,
// hand-computed expectations.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        d_ce, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_sel;
  logic [31:0] d_rdata;
  logic        d_busy, d_done;
  logic        i_ce;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_busy, i_done;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_sel;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  ram_arbiter #(.MAX_D_STREAK(4), .TIMEOUT(255), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .d_ce(d_ce), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_sel(d_sel),
    .d_rdata(d_rdata), .d_busy(d_busy), .d_done(d_done),
    .i_ce(i_ce), .i_addr(i_addr), .i_rdata(i_rdata), .i_busy(i_busy), .i_done(i_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_sel(mem_sel), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, " mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, " mem_addr"}, mem_addr, 32'd0);
    chk({tag, " mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, " mem_sel"}, 32'(mem_sel), 32'd0);
    chk({tag, " d_busy"}, 32'(d_busy), 32'd0);
    chk({tag, " i_busy"}, 32'(i_busy), 32'd0);
    chk({tag, " d_done"}, 32'(d_done), 32'd0);
    chk({tag, " i_done"}, 32'(i_done), 32'd0);
    chk({tag, " d_rdata"}, d_rdata, 32'd0);
    chk({tag, " i_rdata"}, i_rdata, 32'd0);
    chk({tag, " bus_err"}, 32'(bus_err), 32'd0);
  endtask

  // Expected grant order with both requesters always asserting (1 = D, 0 = I)
  logic exp_is_d [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    rst = 1'b1; d_ce = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_sel = 0;
    i_ce = 0; i_addr = 0; mem_ack = 0; mem_rdata = 0;
    tick(); tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // D read, ack one cycle after req
    d_ce = 1; d_we = 0; d_addr = 32'h40; d_sel = 4'b0011;
    tick();
    chk("rd mem_req", 32'(mem_req), 32'd1);
    chk("rd mem_addr", mem_addr, 32'h40);
    chk("rd mem_sel", 32'(mem_sel), 32'h3);
    chk("rd mem_we", 32'(mem_we), 32'd0);
    chk("rd i_busy", 32'(i_busy), 32'd1);
    chk("rd d_busy", 32'(d_busy), 32'd1);
    mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ack = 0;
    chk("rd d_done", 32'(d_done), 32'd1);
    chk("rd d_rdata", d_rdata, 32'hDEADBEEF);
    chk("rd done mem_req", 32'(mem_req), 32'd0);
    chk("rd done i_busy", 32'(i_busy), 32'd1);
    chk("rd done d_busy", 32'(d_busy), 32'd0);
    tick();
    chk("rd after d_done", 32'(d_done), 32'd0);
    chk("rd no reissue", 32'(mem_req), 32'd0);
    chk("rd idle i_busy", 32'(i_busy), 32'd0);
    chk("rd d_rdata hold", d_rdata, 32'hDEADBEEF);
    d_ce = 0;
    tick();

    // D write held until ack
    d_ce = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'h12345678; d_sel = 4'b1111;
    tick();
    chk("wr mem_we", 32'(mem_we), 32'd1);
    chk("wr mem_addr", mem_addr, 32'h100);
    chk("wr mem_wdata", mem_wdata, 32'h12345678);
    d_wdata = 32'hFFFF0000; d_addr = 32'h0;
    tick(); tick();
    chk("wr held mem_req", 32'(mem_req), 32'd1);
    chk("wr held mem_wdata", mem_wdata, 32'h12345678);
    chk("wr held mem_addr", mem_addr, 32'h100);
    mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
    tick();
    mem_ack = 0; d_ce = 0; d_we = 0;
    chk("wr d_done", 32'(d_done), 32'd1);
    chk("wr d_rdata", d_rdata, 32'd0);
    chk("wr bus_err", 32'(bus_err), 32'd0);
    tick();

    // Both requesting: D streak limit forces I every fifth grant
    d_ce = 1; i_ce = 1; d_addr = 32'h200; d_sel = 4'b0001; i_addr = 32'h300;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("arb%0d mem_addr", k), mem_addr, exp_is_d[k] ? 32'h200 : 32'h300);
      chk($sformatf("arb%0d mem_sel", k), 32'(mem_sel), exp_is_d[k] ? 32'h1 : 32'hF);
      mem_ack = 1; mem_rdata = 32'hA5A50000 + 32'(k);
      tick();
      mem_ack = 0;
      chk($sformatf("arb%0d d_done", k), 32'(d_done), 32'(exp_is_d[k]));
      chk($sformatf("arb%0d i_done", k), 32'(i_done), 32'(!exp_is_d[k]));
      chk($sformatf("arb%0d rdata", k), exp_is_d[k] ? d_rdata : i_rdata,
          32'hA5A50000 + 32'(k));
      tick();
    end
    d_ce = 0; i_ce = 0;
    tick();

    // I fetch with no ack: abort after exactly 255 bus cycles
    i_ce = 1; i_addr = 32'h600;
    tick();
    chk("tmo mem_req start", 32'(mem_req), 32'd1);
    for (int n = 0; n < 254; n++) tick();
    chk("tmo mem_req at 254", 32'(mem_req), 32'd1);
    chk("tmo i_done at 254", 32'(i_done), 32'd0);
    tick();
    chk("tmo i_done", 32'(i_done), 32'd1);
    chk("tmo bus_err", 32'(bus_err), 32'd1);
    chk("tmo i_rdata", i_rdata, 32'd0);
    chk("tmo mem_req", 32'(mem_req), 32'd0);
    chk("tmo d_busy", 32'(d_busy), 32'd1);
    i_ce = 0; d_ce = 1; d_we = 0; d_addr = 32'h400; d_sel = 4'b1111;
    tick();
    chk("tmo idle bus_err", 32'(bus_err), 32'd0);
    chk("tmo idle i_done", 32'(i_done), 32'd0);
    chk("tmo idle mem_req", 32'(mem_req), 32'd0);
    tick();
    chk("post-tmo D grant", 32'(mem_req), 32'd1);
    chk("post-tmo D addr", mem_addr, 32'h400);
    mem_ack = 1; mem_rdata = 32'hCAFEF00D;
    tick();
    mem_ack = 0; d_ce = 0;
    chk("post-tmo d_done", 32'(d_done), 32'd1);
    chk("post-tmo d_rdata", d_rdata, 32'hCAFEF00D);
    tick();

    // Reset in the middle of BUS_D
    d_ce = 1; d_addr = 32'h500;
    tick();
    chk("rstmid mem_req", 32'(mem_req), 32'd1);
    rst = 1;
    tick();
    chk_all_zero("rstmid");
    rst = 0; d_ce = 0;
    tick();
    chk("rstmid no d_done", 32'(d_done), 32'd0);
    chk("rstmid no mem_req", 32'(mem_req), 32'd0);
    d_ce = 1; d_addr = 32'h504;
    tick();
    chk("fresh mem_addr", mem_addr, 32'h504);
    mem_ack = 1; mem_rdata = 32'h55AA33CC;
    tick();
    mem_ack = 0; d_ce = 0;
    chk("fresh d_done", 32'(d_done), 32'd1);
    chk("fresh d_rdata", d_rdata, 32'h55AA33CC);
    tick();

    // Stray acks in IDLE and DONE are ignored
    mem_ack = 1; mem_rdata = 32'h00000BAD;
    tick();
    mem_ack = 0;
    chk("idle ack d_done", 32'(d_done), 32'd0);
    chk("idle ack i_done", 32'(i_done), 32'd0);
    chk("idle ack d_rdata", d_rdata, 32'h55AA33CC);
    chk("idle ack mem_req", 32'(mem_req), 32'd0);
    d_ce = 1; d_addr = 32'h508;
    tick();
    mem_ack = 1; mem_rdata = 32'h11112222;
    tick();
    chk("done ack d_done", 32'(d_done), 32'd1);
    d_ce = 0; mem_ack = 1; mem_rdata = 32'h00000099;
    tick();
    mem_ack = 0;
    chk("done ack no pulse", 32'(d_done), 32'd0);
    chk("done ack d_rdata", d_rdata, 32'h11112222);
    chk("done ack i_rdata", i_rdata, 32'd0);
    tick();
    chk("final mem_req", 32'(mem_req), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
